// File: rtl/psum_accum.sv
// rtl/psum_accum.sv - accumulates MAC output FIFO rows into a psum buffer over passes and drains them
// Read issue, rd_lat-deep capture pipe, per-row accumulate, then in-order drain with optional ReLU.
module psum_accum #(
   parameter int col    = 8,
   parameter int bw     = 16,
   parameter int acc_bw = 20,
   parameter int depth  = 16,
   parameter int rd_lat = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [$clog2(depth)-1:0]   num_rows,
   input  logic [7:0]                 num_pass,
   input  logic                       relu_en,
   input  logic                       ofifo_valid,
   input  logic [bw*col-1:0]          ofifo_out,
   output logic                       ofifo_rd,
   output logic [acc_bw*col-1:0]      out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done
);

   localparam int rw = $clog2(depth);
   localparam int tw = rw + 9;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [rw-1:0]          rows_q, rows_d;
   logic [7:0]             pass_q, pass_d;
   logic                   relu_q, relu_d;
   logic [tw-1:0]          issued_q, issued_d;
   logic [rd_lat-1:0]      pipe_q, pipe_d;
   logic [rw-1:0]          wr_row_q, wr_row_d;
   logic [7:0]             wr_pass_q, wr_pass_d;
   logic [rw:0]            rd_row_q, rd_row_d;
   logic                   out_valid_q, out_valid_d;
   logic [acc_bw*col-1:0]  out_data_q, out_data_d;
   logic                   done_q, done_d;

   logic [acc_bw*col-1:0]  mem_q [depth];

   logic [tw-1:0]          total;
   logic                   rd_c;
   logic                   accept;
   logic                   tail;
   logic                   wr_en;
   logic [acc_bw*col-1:0]  wr_data;
   logic [acc_bw*col-1:0]  rd_data;
   logic                   handshake;
   logic                   load;

   function automatic logic [acc_bw-1:0] sext(input logic [bw-1:0] v);
      logic signed [bw-1:0] s;
      s = v;
      return acc_bw'(s);
   endfunction

   always_comb begin
      total     = (tw'(rows_q) + tw'(1)) * (tw'(pass_q) + tw'(1));
      rd_c      = (state_q == S_ACC) && (issued_q < total);
      accept    = rd_c && ofifo_valid;
      tail      = pipe_q[rd_lat-1];
      handshake = out_valid_q && out_ready;
      load      = (state_q == S_DRAIN) && (rd_row_q <= {1'b0, rows_q}) && (!out_valid_q || out_ready);
   end

   // pass 0 overwrites so stale buffer contents from earlier jobs never leak in
   always_comb begin
      wr_data = '0;
      for (int c = 0; c < col; c++) begin
         if (wr_pass_q == 8'd0)
            wr_data[acc_bw*c +: acc_bw] = sext(ofifo_out[bw*c +: bw]);
         else
            wr_data[acc_bw*c +: acc_bw] = mem_q[wr_row_q][acc_bw*c +: acc_bw] + sext(ofifo_out[bw*c +: bw]);
      end
   end

   always_comb begin
      rd_data = mem_q[rd_row_q[rw-1:0]];
      for (int c = 0; c < col; c++) begin
         if (relu_q && rd_data[acc_bw*c + acc_bw - 1])
            rd_data[acc_bw*c +: acc_bw] = '0;
      end
   end

   always_comb begin
      state_d     = state_q;
      rows_d      = rows_q;
      pass_d      = pass_q;
      relu_d      = relu_q;
      issued_d    = issued_q;
      wr_row_d    = wr_row_q;
      wr_pass_d   = wr_pass_q;
      rd_row_d    = rd_row_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      wr_en       = 1'b0;
      pipe_d[0]   = accept;
      for (int k = 1; k < rd_lat; k++)
         pipe_d[k] = pipe_q[k-1];

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_ACC;
               rows_d    = num_rows;
               pass_d    = num_pass;
               relu_d    = relu_en;
               issued_d  = '0;
               wr_row_d  = '0;
               wr_pass_d = '0;
            end
         end
         S_ACC: begin
            if (accept)
               issued_d = issued_q + tw'(1);
            if (tail) begin
               wr_en = 1'b1;
               if (wr_row_q == rows_q) begin
                  wr_row_d  = '0;
                  wr_pass_d = wr_pass_q + 8'd1;
               end else begin
                  wr_row_d  = wr_row_q + rw'(1);
               end
            end
            if ((issued_q == total) && (pipe_q == '0)) begin
               state_d  = S_DRAIN;
               rd_row_d = '0;
            end
         end
         S_DRAIN: begin
            if (handshake)
               out_valid_d = 1'b0;
            if (load) begin
               out_valid_d = 1'b1;
               out_data_d  = rd_data;
               rd_row_d    = rd_row_q + (rw+1)'(1);
            end else if (handshake) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rows_q      <= '0;
         pass_q      <= '0;
         relu_q      <= 1'b0;
         issued_q    <= '0;
         pipe_q      <= '0;
         wr_row_q    <= '0;
         wr_pass_q   <= '0;
         rd_row_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         pass_q      <= pass_d;
         relu_q      <= relu_d;
         issued_q    <= issued_d;
         pipe_q      <= pipe_d;
         wr_row_q    <= wr_row_d;
         wr_pass_q   <= wr_pass_d;
         rd_row_q    <= rd_row_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && wr_en)
         mem_q[wr_row_q] <= wr_data;
   end

   assign ofifo_rd  = rd_c;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;

endmodule
